result_uart_tx: RTL
===================

// Module: result_uart_tx
// PURPOSE
//  Sending end of the 10-bit result path: captures a 10-bit result on a start pulse and serialises it
//  off-chip as a self-synchronising two-byte 8N1 UART frame. Sits downstream of the result-holding register.
//  A host PC reassembles the value: the header byte is flagged by bit7=1 and the low byte by bit7=0.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal range >= 2
//  DATA_W        10   result width; fixed at 10, and any other value is a synthesis error
// PORTS
//  clk        in   1   system clock; one clock domain only
//  rst        in   1   reset; synchronous, active-high
//  result_in  in   10  value to send; sampled only in the cycle a start is accepted
//  start      in   1   request to send; accepted when rst=0 and busy=0
//  tx         out  1   UART serial line; idles high
//  busy       out  1   high while a frame is in flight
//  done       out  1   one-cycle pulse when the frame completes
// BEHAVIOUR
//  - Reset values: tx=1, busy=0, done=0, state=IDLE, all counters=0, shadow register=0.
//  - Accept: at an edge where start=1, busy=0 and rst=0, the block latches result_in into a shadow register.
//    In the next cycle busy=1 and tx=0 (start bit). Latency from start to the first tx edge is 1 cycle.
//  - start while busy=1: ignored and not queued. Changes on result_in during a frame have no effect.
//  - Frame: two back-to-back bytes with no idle gap, each sent as start(0), 8 data bits LSB-first, stop(1).
//    Each bit lasts exactly CLKS_PER_BIT cycles.
//    Byte0 = {1'b1, 4'b0000, r[9:7]}; Byte1 = {1'b0, r[6:0]}.
//  - Frame length is 20*CLKS_PER_BIT cycles. busy is high for exactly that many cycles after acceptance.
//  - Completion: in the cycle after the last stop-bit period ends, busy=0, done=1 for one cycle, tx=1.
//  - Back-to-back: a start in the done cycle is accepted, and its start bit appears on the next cycle.
//  - State machine: IDLE -> START_BIT -> DATA_BITS (bit_idx 0..7) -> STOP_BIT.
//    From STOP_BIT: go to START_BIT if byte_idx=0, otherwise go to IDLE.
//    byte_idx toggles on each transition STOP_BIT -> START_BIT.
//  - Counters: baud counter counts 0..CLKS_PER_BIT-1 and wraps. Width is $clog2(CLKS_PER_BIT).
//    bit_idx is 3 bits and byte_idx is 1 bit.
//  - tx is driven from a register (glitch-free); it is never driven combinationally from the state.
//  - rst mid-frame: at the next edge tx=1, busy=0 and done=0. The partial frame is abandoned.
//    rst has priority over start.
// STRUCTURE
//  - Shared include result_pkg.vh holds: RESULT_W=10, the header-flag bit position (7), the state
//    encodings (IDLE=2'd0, START_BIT=2'd1, DATA_BITS=2'd2, STOP_BIT=2'd3) and the default CLKS_PER_BIT.
//  - One sub-module, uart_byte_tx (CLKS_PER_BIT; ports clk, rst, data[7:0], send, tx, ready).
//    It contains the baud counter and the single-byte state machine.
//  - The top level owns the shadow register, byte sequencing (byte_idx), byte formatting, and busy/done.
// TESTING  (bench uses CLKS_PER_BIT=4, so one frame is 80 cycles)
//  1. Apply rst for 3 cycles, then release -> tx=1, busy=0, done=0 throughout, and tx never toggles.
//  2. start=1 for 1 cycle with result_in=10'h2AB -> bytes decoded are 0x85 then 0x2B.
//     busy is high for exactly 80 cycles, and done is a single pulse in cycle 81.
//  3. result_in=10'h3FF, then 10'h000 -> bytes 0x87/0x7F, then 0x80/0x00.
//     Bit7 is 1 on the first byte only.
//  4. Pulse start again at cycle 30 of a frame, and change result_in mid-frame -> the second start is ignored,
//     and the frame carries the originally latched value.
//  5. Hold start high continuously with result_in=10'h155 -> frames are back-to-back.
//     Each frame is 0x82/0x55, with exactly 1 idle cycle (tx=1) between the final stop bit and the next start bit.
//  6. Assert rst during byte1's data bits -> tx=1 and busy=0 on the next cycle, and no done pulse.
//     A fresh start afterwards sends a full, correct frame.

Source files
------------

// File: rtl/result_uart_tx_pkg.sv
// result_uart_tx_pkg: shared widths, state encoding and byte formatting for the result UART path
package result_uart_tx_pkg;

    localparam int RESULT_W         = 10;
    localparam int HDR_BIT          = 7;
    localparam int DEF_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } uart_state_e;

    // Header byte carries the top bits with bit7 set; low byte carries the rest with bit7 clear
    function automatic logic [7:0] fmt_byte(input logic [RESULT_W-1:0] r, input logic idx);
        logic [7:0] b;
        b = idx ? 8'(r[HDR_BIT-1:0]) : 8'(r >> HDR_BIT);
        b[HDR_BIT] = ~idx;
        return b;
    endfunction

endpackage

// File: rtl/result_uart_tx_byte.sv
// uart_byte_tx: single-byte 8N1 serialiser with baud counter, able to chain bytes without a gap
module uart_byte_tx
    import result_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       send,
    output logic       tx,
    output logic       ready
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          wrap;

    assign wrap  = cnt_q == LAST;
    assign ready = (state_q == IDLE) || (state_q == STOP_BIT && wrap);
    assign tx    = tx_q;

    // Next state: data is shifted out LSB-first, a send at the end of a stop bit chains the next byte
    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == IDLE || wrap) ? '0 : cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        tx_d      = tx_q;
        case (state_q)
            IDLE: if (send) begin
                state_d = START_BIT;
                data_d  = data;
                tx_d    = 1'b0;
            end
            START_BIT: if (wrap) begin
                state_d   = DATA_BITS;
                bit_idx_d = '0;
                tx_d      = data_q[0];
                data_d    = {1'b0, data_q[7:1]};
            end
            DATA_BITS: if (wrap) begin
                if (bit_idx_q == 3'd7) begin
                    state_d = STOP_BIT;
                    tx_d    = 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    tx_d      = data_q[0];
                    data_d    = {1'b0, data_q[7:1]};
                end
            end
            default: if (wrap) begin
                state_d = send ? START_BIT : IDLE;
                data_d  = send ? data : data_q;
                tx_d    = ~send;
            end
        endcase
    end

    // State register; tx comes straight from a flop so the line never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx: latches a 10-bit result and sends it as a header byte plus a low byte over UART
module result_uart_tx
    import result_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_W       = RESULT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] result_in,
    input  logic              start,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    if (DATA_W != RESULT_W) begin : g_bad_width
        $error("result_uart_tx supports only a 10-bit result");
    end

    logic [RESULT_W-1:0] shadow_q, shadow_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                byte_idx_q, byte_idx_d;
    logic                accept, last, ready, send;
    logic [7:0]          data;

    // A new frame sends its header straight from result_in; the low byte comes from the shadow copy
    always_comb begin
        accept     = start && !busy_q;
        last       = busy_q && ready && byte_idx_q;
        send       = accept || (busy_q && ready && !byte_idx_q);
        data       = fmt_byte(accept ? RESULT_W'(result_in) : shadow_q, ~accept);
        shadow_d   = accept ? RESULT_W'(result_in) : shadow_q;
        busy_d     = accept || (busy_q && !last);
        byte_idx_d = (busy_q && ready) ? ~byte_idx_q : byte_idx_q;
        done_d     = last;
    end

    // Frame bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_idx_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .send  (send),
        .tx    (tx),
        .ready (ready)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule
